dsm_dem_decimator: RTL and testbench

DSM_DEM_DECIMATOR -- requirements
Module: dsm_dem_decimator

---
 rtl/dsm_pkg.sv | 12 +
 rtl/cic3_chan.sv | 56 +++++
 rtl/dsm_dem_decimator.sv | 45 ++++
 tb/tb_dsm_dem_decimator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared constants and the output-width derivation for the DEM decimator
package dsm_pkg;
  localparam int DEM_ELEMS = 16;
  localparam int LEVEL_OFFSET = 8;
  localparam int CIC_ORDER = 3;
  localparam int OSR_DEF = 32;
  localparam int WARMUP_EVENTS = 3;
  function automatic int cic_ow(input int osr);
    return 5 + CIC_ORDER * $clog2(osr);
  endfunction
  localparam int OW_DEF = cic_ow(OSR_DEF);
endpackage

// File: rtl/cic3_chan.sv
// cic3_chan: one channel of popcount level extraction plus 3rd-order CIC integrators and combs
module cic3_chan
  import dsm_pkg::*;
#(
  parameter int OW = OW_DEF
) (
  input  logic                 mclk512,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 strobe,
  input  logic                 dec_evt,
  input  logic                 emit,
  input  logic [DEM_ELEMS-1:0] dem_in,
  output logic [OW-1:0]        pcm
);
  localparam int PW = $clog2(DEM_ELEMS + 1);
  logic [PW-1:0] ones;
  logic [OW-1:0] x, i1, i2, i3, i1_n, i2_n, i3_n, c_in, d1, d2, d3, y1, y2, y3;
  // count selected unit elements
  always_comb begin
    ones = '0;
    for (int k = 0; k < DEM_ELEMS; k++) ones = ones + PW'(dem_in[k]);
  end
  assign x    = OW'(ones) - OW'(LEVEL_OFFSET);
  assign i1_n = i1 + x;
  assign i2_n = i2 + i1_n;
  assign i3_n = i3 + i2_n;
  assign y1   = c_in - d1;
  assign y2   = y1 - d2;
  assign y3   = y2 - d3;
  // integrators advance per strobe; comb delays shift only on decimation events so the
  // comb itself can be evaluated the cycle after the event from the latched sample
  always_ff @(posedge mclk512 or negedge reset_n)
    if (!reset_n) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      c_in <= '0; d1 <= '0; d2 <= '0; d3 <= '0;
      pcm <= '0;
    end else if (clr) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      c_in <= '0; d1 <= '0; d2 <= '0; d3 <= '0;
      pcm <= '0;
    end else begin
      if (strobe) begin
        i1 <= i1_n;
        i2 <= i2_n;
        i3 <= i3_n;
      end
      if (dec_evt) begin
        c_in <= i3_n;
        d1 <= c_in;
        d2 <= y1;
        d3 <= y2;
      end
      if (emit) pcm <= y3;
    end
endmodule

// File: rtl/dsm_dem_decimator.sv
// dsm_dem_decimator: stereo DEM-vector to PCM decimator with shared decimation and warm-up control
module dsm_dem_decimator
  import dsm_pkg::*;
#(
  parameter int OSR = OSR_DEF,
  parameter int OW  = cic_ow(OSR)
) (
  input  logic                 mclk512,
  input  logic                 reset_n,
  input  logic [1:0]           dem_count,
  input  logic [DEM_ELEMS-1:0] dem_in_l,
  input  logic [DEM_ELEMS-1:0] dem_in_r,
  input  logic                 dec_clr,
  output logic [OW-1:0]        pcm_l,
  output logic [OW-1:0]        pcm_r,
  output logic                 pcm_valid
);
  localparam int CW = $clog2(OSR);
  logic          strobe, dec_evt, warm_done, pend;
  logic [CW-1:0] dec_cnt;
  logic [1:0]    warm;
  assign strobe    = dem_count == 2'b00;
  assign dec_evt   = strobe && dec_cnt == CW'(OSR - 1);
  assign warm_done = warm == 2'(WARMUP_EVENTS);
  // decimation counter, warm-up gate and the two-stage event-to-valid pipeline
  always_ff @(posedge mclk512 or negedge reset_n)
    if (!reset_n) begin
      dec_cnt <= '0; warm <= '0; pend <= 1'b0; pcm_valid <= 1'b0;
    end else if (dec_clr) begin
      dec_cnt <= '0; warm <= '0; pend <= 1'b0; pcm_valid <= 1'b0;
    end else begin
      if (strobe) dec_cnt <= dec_cnt + CW'(1);
      if (dec_evt && !warm_done) warm <= warm + 2'd1;
      pend <= dec_evt && warm_done;
      pcm_valid <= pend;
    end
  cic3_chan #(.OW(OW)) u_l (
    .mclk512(mclk512), .reset_n(reset_n), .clr(dec_clr), .strobe(strobe),
    .dec_evt(dec_evt), .emit(pend), .dem_in(dem_in_l), .pcm(pcm_l)
  );
  cic3_chan #(.OW(OW)) u_r (
    .mclk512(mclk512), .reset_n(reset_n), .clr(dec_clr), .strobe(strobe),
    .dec_evt(dec_evt), .emit(pend), .dem_in(dem_in_r), .pcm(pcm_r)
  );
endmodule

// File: tb/tb_dsm_dem_decimator.sv
// tb_dsm_dem_decimator: scoreboard bench using an impulse-response model of the CIC
module tb_dsm_dem_decimator;
  localparam int R  = 32;
  localparam int OW = 20;
  localparam int HL = 3 * R - 2;
  localparam int FS = 262144;
  typedef struct {int l; int r; int due;} exp_t;
  logic          mclk512 = 1'b0;
  logic          reset_n = 1'b0;
  logic          dec_clr = 1'b0;
  logic [1:0]    dem_count = 2'd0;
  logic [15:0]   dem_in_l = '0, dem_in_r = '0;
  logic [OW-1:0] pcm_l, pcm_r;
  logic          pcm_valid;
  exp_t sb[$];
  exp_t e;
  int   hist_l[$], hist_r[$];
  int   h[HL];
  int   sc = 0, cyc = 0, fs = -1, passes = 0, total = 0;
  logic [1:0] ph = 2'd0;

  dsm_dem_decimator #(.OSR(R), .OW(OW)) dut (
    .mclk512(mclk512), .reset_n(reset_n), .dem_count(dem_count),
    .dem_in_l(dem_in_l), .dem_in_r(dem_in_r), .dec_clr(dec_clr),
    .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid)
  );

  always #5 mclk512 = ~mclk512;

  function automatic int sx(input logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int lvl(input logic [15:0] v);
    return $countones(v) - 8;
  endfunction

  // one cycle of stimulus; vectors are garbage except on strobes, expected outputs queued per event
  task automatic tick(input logic [15:0] l, input logic [15:0] r);
    int yl, yr;
    dem_count = ph;
    dem_in_l = (ph == 2'd0) ? l : 16'($urandom);
    dem_in_r = (ph == 2'd0) ? r : 16'($urandom);
    if (!reset_n || dec_clr) begin
      sc = 0;
      hist_l.delete();
      hist_r.delete();
      sb.delete();
    end else if (ph == 2'd0) begin
      sc++;
      if (sc == 1) fs = cyc;
      hist_l.push_front(lvl(l));
      hist_r.push_front(lvl(r));
      if (hist_l.size() > HL) begin
        yl = hist_l.pop_back();
        yr = hist_r.pop_back();
      end
      if (sc % R == 0 && sc / R >= 4) begin
        yl = 0;
        yr = 0;
        for (int j = 0; j < hist_l.size(); j++) begin
          yl += h[j] * hist_l[j];
          yr += h[j] * hist_r[j];
        end
        sb.push_back('{yl, yr, cyc + 2});
      end
    end
    @(posedge mclk512);
    @(negedge mclk512);
    ph = ph + 2'd1;
  endtask

  // scoreboard: every pcm_valid must match the queued event in time and value
  always @(posedge mclk512) begin
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      total++;
      $display("FAIL missed_valid: pcm_valid low at cycle %0d, required high", sb[0].due);
      e = sb.pop_front();
    end
    if (pcm_valid) begin
      total++;
      if (sb.size() == 0 || sb[0].due != cyc)
        $display("FAIL valid_timing: pcm_valid high at cycle %0d, required low", cyc);
      else begin
        e = sb.pop_front();
        if (sx(pcm_l) == e.l && sx(pcm_r) == e.r) passes++;
        else $display("FAIL pcm_value: got l=%0d r=%0d, required l=%0d r=%0d",
                      sx(pcm_l), sx(pcm_r), e.l, e.r);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick(16'hFFFF, 16'hFFFF);
    total++; if (pcm_l === '0) passes++; else $display("FAIL reset_pcm_l: got %0d, required 0", sx(pcm_l));
    total++; if (pcm_r === '0) passes++; else $display("FAIL reset_pcm_r: got %0d, required 0", sx(pcm_r));
    total++; if (pcm_valid === 1'b0) passes++; else $display("FAIL reset_valid: got %b, required 0", pcm_valid);
    reset_n = 1'b1;
  endtask

  task automatic test_all_ones();
    int nv = 0, prev = 0;
    for (int n = 0; n < 7 * 4 * R; n++) begin
      tick(16'hFFFF, 16'hFFFF);
      if (pcm_valid) begin
        total++;
        if (nv == 0 ? cyc == fs + 2 + (4 * R - 1) * 4 : cyc - prev == 4 * R) passes++;
        else $display("FAIL ones_spacing: valid at cycle %0d, previous %0d, first strobe %0d", cyc, prev, fs);
        total++;
        if (sx(pcm_l) == FS && sx(pcm_r) == FS) passes++;
        else $display("FAIL ones_level: got l=%0d r=%0d, required %0d", sx(pcm_l), sx(pcm_r), FS);
        prev = cyc;
        nv++;
      end
    end
    total++; if (nv >= 3) passes++; else $display("FAIL ones_count: got %0d valids, required >= 3", nv);
  endtask

  task automatic test_split();
    int ll = 0, lr = 0;
    for (int n = 0; n < 6 * 4 * R; n++) begin
      tick(16'h0000, 16'hFFFF);
      if (pcm_valid) begin
        ll = sx(pcm_l);
        lr = sx(pcm_r);
      end
    end
    total++; if (ll == -FS) passes++; else $display("FAIL split_left: got %0d, required %0d", ll, -FS);
    total++; if (lr == FS) passes++; else $display("FAIL split_right: got %0d, required %0d", lr, FS);
  endtask

  task automatic test_rotating();
    logic [15:0] pat [3] = '{16'h00FF, 16'h0FF0, 16'hFF00};
    int ll = 1, lr = 1;
    for (int n = 0; n < 6 * 4 * R; n++) begin
      tick(pat[sc % 3], pat[(sc + 1) % 3]);
      if (pcm_valid) begin
        ll = sx(pcm_l);
        lr = sx(pcm_r);
      end
    end
    total++; if (ll == 0 && lr == 0) passes++;
    else $display("FAIL rotating_zero: got l=%0d r=%0d, required 0", ll, lr);
  endtask

  task automatic test_step();
    int pl = -FS, pr = -FS;
    dec_clr = 1'b1;
    tick(16'h0000, 16'h0000);
    dec_clr = 1'b0;
    while (sc < 5 * R) tick(16'h0000, 16'h0000);
    while (sc < 8 * R || ph != 2'd3) begin
      tick(16'hFFFF, 16'hFFFF);
      if (pcm_valid) begin
        total++;
        if (sx(pcm_l) >= pl && sx(pcm_r) >= pr && sx(pcm_l) <= FS && sx(pcm_r) <= FS) passes++;
        else $display("FAIL step_monotonic: got l=%0d r=%0d after l=%0d r=%0d", sx(pcm_l), sx(pcm_r), pl, pr);
        pl = sx(pcm_l);
        pr = sx(pcm_r);
      end
    end
    total++; if (pl == FS && pr == FS) passes++;
    else $display("FAIL step_settle: got l=%0d r=%0d, required %0d", pl, pr, FS);
  endtask

  task automatic test_clr_on_event();
    int nv = 0;
    while (!(ph == 2'd0 && sc % R == R - 1)) tick(16'hFFFF, 16'hFFFF);
    dec_clr = 1'b1;
    tick(16'hFFFF, 16'hFFFF);
    dec_clr = 1'b0;
    total++; if (pcm_l === '0 && pcm_r === '0) passes++;
    else $display("FAIL clr_pcm: got l=%0d r=%0d, required 0", sx(pcm_l), sx(pcm_r));
    total++; if (pcm_valid === 1'b0) passes++; else $display("FAIL clr_valid: got %b, required 0", pcm_valid);
    while (sc < 5 * R) begin
      tick(16'hFFFF, 16'hFFFF);
      nv += int'(pcm_valid);
    end
    repeat (3) begin
      tick(16'hFFFF, 16'hFFFF);
      nv += int'(pcm_valid);
    end
    total++; if (nv == 2) passes++; else $display("FAIL clr_warmup: got %0d valids, required 2", nv);
  endtask

  task automatic test_reset_mid();
    int first = -1, val = 0;
    while (!(ph == 2'd0 && sc % R == 16)) tick(16'hFFFF, 16'hFFFF);
    dem_count = 2'd0;
    reset_n = 1'b0;
    #1;
    sb.delete();
    total++; if (pcm_l === '0 && pcm_r === '0) passes++;
    else $display("FAIL midreset_pcm: got l=%0d r=%0d, required 0", sx(pcm_l), sx(pcm_r));
    total++; if (pcm_valid === 1'b0) passes++; else $display("FAIL midreset_valid: got %b, required 0", pcm_valid);
    repeat (3) tick(16'hFFFF, 16'hFFFF);
    reset_n = 1'b1;
    while (sc < 4 * R) tick(16'hFFFF, 16'hFFFF);
    repeat (3) begin
      tick(16'hFFFF, 16'hFFFF);
      if (pcm_valid && first < 0) begin
        first = cyc;
        val = sx(pcm_l);
      end
    end
    total++; if (first == fs + 2 + (4 * R - 1) * 4) passes++;
    else $display("FAIL midreset_latency: first valid at %0d, required %0d", first, fs + 2 + (4 * R - 1) * 4);
    total++; if (val == FS) passes++; else $display("FAIL midreset_level: got %0d, required %0d", val, FS);
  endtask

  initial begin
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a + b + c]++;
    test_reset();
    test_all_ones();
    test_split();
    test_rotating();
    test_step();
    test_clr_on_event();
    test_reset_mid();
    repeat (8) tick(16'hFFFF, 16'hFFFF);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
